// File: rtl/ldgm_pkg.sv
// Shared constants and FSM encoding for the
// sparse-vector generator scheduler.
package ldgm_pkg;

    localparam int IDX_W   = 14;
    localparam int IDX_MAX = 9799;
    localparam int VEC_LEN = 9800;

    localparam logic MODE_STEP10 = 1'b0;
    localparam logic MODE_STEP50 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_CLR   = 3'd2,
        ST_START = 3'd3,
        ST_BUSY  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester after
// ptr wins, wrapping; grant is one-hot.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt
);

    logic found;

    // Scan from ptr+1 around to ptr, grant first hit.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (en && !found &&
                req[(int'(ptr) + i) % N_REQ]) begin
                gnt[(int'(ptr) + i) % N_REQ] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vec_gen_scheduler.sv
// Shares one sparse-vector generator between
// requesters: arbitrate, clear, start, wait, report.
module vec_gen_scheduler #(
    parameter int N_REQ   = 2,
    parameter int IDX_W   = 14,
    parameter int IDX_MAX = 9799,
    parameter int CLR_CYC = 2,
    parameter int TIMEOUT = 1200,
    parameter int TO_W    = 11
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_mode,
    input  logic [N_REQ*IDX_W-1:0] req_idx,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [N_REQ-1:0]       err,
    output logic                   vec_valid,
    output logic                   busy,
    output logic                   gen_rst_b,
    output logic                   gen_start,
    output logic                   gen_mode,
    output logic [IDX_W-1:0]       gen_idx,
    input  logic                   gen_finish
);

    import ldgm_pkg::*;

    localparam int PW =
        (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t            state_q;
    state_t            state_d;
    logic [N_REQ-1:0]  arb_gnt;
    logic [N_REQ-1:0]  own_q;
    logic [PW-1:0]     own_idx;
    logic [PW-1:0]     ptr_q;
    logic [TO_W-1:0]   cnt_q;
    logic [IDX_W-1:0]  idx_sel;
    logic              mode_sel;
    logic              bad_idx;
    logic              rdy_q;
    logic              vv_q;
    logic              mode_q;
    logic [IDX_W-1:0]  idx_q;

    assign gen_mode = mode_q;
    assign gen_idx  = idx_q;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .en  (state_q == ST_IDLE),
        .gnt (arb_gnt)
    );

    // Owner index and its request fields.
    always_comb begin
        own_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (own_q[i]) own_idx = PW'(i);
        end
        idx_sel  = req_idx[int'(own_idx)*IDX_W +: IDX_W];
        mode_sel = req_mode[own_idx];
        bad_idx  = int'(idx_sel) > IDX_MAX;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and job outputs.
    always_comb begin
        state_d   = state_q;
        gnt       = own_q;
        done      = '0;
        err       = '0;
        busy      = 1'b1;
        gen_start = 1'b0;
        gen_rst_b = rdy_q;
        vec_valid = vv_q;
        unique case (state_q)
            ST_IDLE: begin
                gnt  = '0;
                busy = 1'b0;
                if (|req) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                state_d = bad_idx ? ST_ERR : ST_CLR;
            end
            ST_CLR: begin
                gen_rst_b = 1'b0;
                vec_valid = 1'b0;
                if (cnt_q == TO_W'(CLR_CYC-1))
                    state_d = ST_START;
            end
            ST_START: begin
                gen_start = 1'b1;
                state_d   = ST_BUSY;
            end
            ST_BUSY: begin
                if (gen_finish)
                    state_d = ST_DONE;
                else if (cnt_q == TO_W'(TIMEOUT-1))
                    state_d = ST_ERR;
            end
            ST_DONE: begin
                done      = own_q;
                vec_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_ERR: begin
                err       = own_q;
                vec_valid = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                gnt     = '0;
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Owner, pointer, counter and generator regs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            own_q  <= '0;
            ptr_q  <= PW'(N_REQ-1);
            cnt_q  <= '0;
            rdy_q  <= 1'b0;
            vv_q   <= 1'b0;
            mode_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            rdy_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (|req) own_q <= arb_gnt;
                end
                ST_GRANT: begin
                    cnt_q <= '0;
                    if (!bad_idx) begin
                        mode_q <= mode_sel;
                        idx_q  <= idx_sel;
                    end
                end
                ST_CLR: begin
                    cnt_q <= cnt_q + 1'b1;
                    vv_q  <= 1'b0;
                end
                ST_START: cnt_q <= '0;
                ST_BUSY:  cnt_q <= cnt_q + 1'b1;
                ST_DONE: begin
                    vv_q  <= 1'b1;
                    ptr_q <= own_idx;
                end
                ST_ERR: begin
                    vv_q  <= 1'b0;
                    ptr_q <= own_idx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_gen_scheduler.sv
// Directed bench for vec_gen_scheduler with a
// behavioural sparse-vector generator model.
module tb_vec_gen_scheduler;

    localparam int N   = 2;
    localparam int IW  = 14;
    localparam int TO  = 1200;
    localparam int VL  = 9800;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  req_mode = '0;
    logic [IW-1:0] idx0 = '0;
    logic [IW-1:0] idx1 = '0;
    logic [N-1:0]  gnt, done, err;
    logic          vec_valid, busy;
    logic          gen_rst_b, gen_start, gen_mode;
    logic [IW-1:0] gen_idx;
    logic          gen_finish = 1'b0;

    int n_run = 0;
    int n_fail = 0;

    // generator model state
    logic [VL-1:0] gvec = '0;
    logic          grun = 1'b0;
    int            gcnt = 0;
    int            gen_run = 3;
    logic          withhold = 1'b0;

    // monitor state
    int            cyc = 0;
    int            t_start = 0;
    int            t_gnt = 0;
    int            n_start = 0;
    int            n_clr = 0;
    int            n_done = 0;
    int            n_err = 0;
    logic [N-1:0]  prev_gnt = '0;
    logic [N-1:0]  gnt_log[$];

    always #5 clk = ~clk;

    vec_gen_scheduler dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .req        (req),
        .req_mode   (req_mode),
        .req_idx    ({idx1, idx0}),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .vec_valid  (vec_valid),
        .busy       (busy),
        .gen_rst_b  (gen_rst_b),
        .gen_start  (gen_start),
        .gen_mode   (gen_mode),
        .gen_idx    (gen_idx),
        .gen_finish (gen_finish)
    );

    // Generator: gen_run cycles after start, pulse finish.
    always @(posedge clk) begin
        gen_finish <= 1'b0;
        if (!gen_rst_b) begin
            grun <= 1'b0;
            gvec <= '0;
        end else if (gen_start) begin
            grun <= 1'b1;
            gcnt <= gen_run;
        end else if (grun && !withhold) begin
            if (gcnt <= 1) begin
                grun       <= 1'b0;
                gen_finish <= 1'b1;
                if (int'(gen_idx) < VL)
                    gvec[gen_idx] <= 1'b1;
            end else begin
                gcnt <= gcnt - 1;
            end
        end
    end

    // Record per-cycle events at the end of each cycle.
    always @(posedge clk) begin
        if (gen_start) begin
            n_start++;
            t_start = cyc;
        end
        if (busy && !gen_rst_b) n_clr++;
        if (|done) n_done++;
        if (|err) n_err++;
        if (gnt != '0 && prev_gnt == '0) begin
            gnt_log.push_back(gnt);
            t_gnt = cyc;
        end
        prev_gnt = gnt;
        cyc++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_evt(input string tag,
                            input int maxc);
        int k;
        k = 0;
        tick();
        while (!(|done || |err) && k < maxc) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, (|done || |err)}, 32'd1);
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        tick();
        tick();
        rst_b = 1'b1;
        tick();
        tick();
    endtask

    int c0;
    int d0;
    int nd;
    int ne;
    int k;

    initial begin
        // reset values
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vv", 32'(vec_valid), 32'd0);
        chk("rst_start", 32'(gen_start), 32'd0);
        chk("rst_genrst", 32'(gen_rst_b), 32'd0);
        chk("rst_mode_idx", 32'({gen_mode, gen_idx}), 32'd0);
        rst_b = 1'b1;
        tick();
        tick();
        chk("idle_genrst", 32'(gen_rst_b), 32'd1);

        // 1: single job, req0 idx 0
        gen_run = 3;
        n_clr = 0;
        n_start = 0;
        idx0 = 14'd0;
        req_mode = 2'b00;
        req = 2'b01;
        c0 = cyc;
        wait_evt("t1_wait", 50);
        chk("t1_done", 32'(done), 32'b01);
        chk("t1_err", 32'(err), 32'b00);
        chk("t1_gnt", 32'(gnt), 32'b01);
        chk("t1_vv", 32'(vec_valid), 32'd1);
        chk("t1_bit0", 32'(gvec[0]), 32'd1);
        chk("t1_nclr", n_clr, 32'd2);
        chk("t1_nstart", n_start, 32'd1);
        chk("t1_lat_start", t_start - c0, 32'd4);
        chk("t1_lat_done", cyc - t_start, 32'd5);
        req = 2'b00;
        tick();
        chk("t1_gnt_drop", 32'(gnt), 32'd0);
        chk("t1_done_1cyc", 32'(done), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_vv_keep", 32'(vec_valid), 32'd1);

        // 2: simultaneous requests after fresh reset
        do_reset();
        gen_run = 2;
        idx0 = 14'd25;
        idx1 = 14'd123;
        req_mode = 2'b10;
        req = 2'b11;
        wait_evt("t2_wait_a", 50);
        chk("t2_done_a", 32'(done), 32'b01);
        chk("t2_bit25", 32'(gvec[25]), 32'd1);
        chk("t2_mode_a", 32'(gen_mode), 32'd0);
        chk("t2_idx_a", 32'(gen_idx), 32'd25);
        d0 = cyc;
        req = 2'b10;
        wait_evt("t2_wait_b", 50);
        chk("t2_done_b", 32'(done), 32'b10);
        chk("t2_bit123", 32'(gvec[123]), 32'd1);
        chk("t2_bit25_clr", 32'(gvec[25]), 32'd0);
        chk("t2_mode_b", 32'(gen_mode), 32'd1);
        chk("t2_idx_b", 32'(gen_idx), 32'd123);
        chk("t2_gap", t_gnt - d0, 32'd2);
        req = 2'b00;
        tick();

        // 3: req1 held, req0 joins -> 1,0,1
        gnt_log.delete();
        gen_run = 1;
        idx1 = 14'd5;
        idx0 = 14'd7;
        req_mode = 2'b00;
        req = 2'b10;
        wait_evt("t3_wait_a", 50);
        chk("t3_done_a", 32'(done), 32'b10);
        req = 2'b11;
        wait_evt("t3_wait_b", 50);
        chk("t3_done_b", 32'(done), 32'b01);
        req = 2'b10;
        wait_evt("t3_wait_c", 50);
        chk("t3_done_c", 32'(done), 32'b10);
        req = 2'b00;
        tick();
        chk("t3_nlog", gnt_log.size(), 32'd3);
        if (gnt_log.size() == 3) begin
            chk("t3_g0", 32'(gnt_log[0]), 32'b10);
            chk("t3_g1", 32'(gnt_log[1]), 32'b01);
            chk("t3_g2", 32'(gnt_log[2]), 32'b10);
        end
        tick();

        // 4: illegal index
        n_start = 0;
        n_clr = 0;
        idx0 = 14'd9800;
        req = 2'b01;
        wait_evt("t4_wait", 20);
        chk("t4_err", 32'(err), 32'b01);
        chk("t4_done", 32'(done), 32'b00);
        chk("t4_lat", cyc - t_gnt, 32'd1);
        chk("t4_vv", 32'(vec_valid), 32'd0);
        chk("t4_nstart", n_start, 32'd0);
        chk("t4_nclr", n_clr, 32'd0);
        req = 2'b00;
        tick();
        chk("t4_err_1cyc", 32'(err), 32'd0);

        // 5: timeout, then next request served
        withhold = 1'b1;
        idx0 = 14'd50;
        req = 2'b01;
        wait_evt("t5_wait", TO + 50);
        chk("t5_err", 32'(err), 32'b01);
        chk("t5_lat", cyc - t_start, TO + 1);
        chk("t5_vv", 32'(vec_valid), 32'd0);
        req = 2'b00;
        withhold = 1'b0;
        tick();
        chk("t5_idle", 32'(busy), 32'd0);
        gen_run = 2;
        idx1 = 14'd60;
        req = 2'b10;
        wait_evt("t5_wait_b", 50);
        chk("t5_done_b", 32'(done), 32'b10);
        chk("t5_bit60", 32'(gvec[60]), 32'd1);
        req = 2'b00;
        tick();

        // 6: async reset during BUSY
        withhold = 1'b1;
        idx0 = 14'd77;
        req_mode = 2'b01;
        req = 2'b01;
        k = 0;
        while (!gen_start && k < 20) begin
            tick();
            k++;
        end
        chk("t6_started", 32'(gen_start), 32'd1);
        tick();
        tick();
        tick();
        chk("t6_busy", 32'(busy), 32'd1);
        nd = n_done;
        ne = n_err;
        rst_b = 1'b0;
        req = 2'b00;
        #1;
        chk("t6_gnt", 32'(gnt), 32'd0);
        chk("t6_busy0", 32'(busy), 32'd0);
        chk("t6_genrst", 32'(gen_rst_b), 32'd0);
        chk("t6_mode", 32'(gen_mode), 32'd0);
        chk("t6_idx", 32'(gen_idx), 32'd0);
        chk("t6_start", 32'(gen_start), 32'd0);
        tick();
        tick();
        tick();
        chk("t6_no_evt", n_done + n_err, nd + ne);
        rst_b = 1'b1;
        withhold = 1'b0;
        tick();
        tick();
        gen_run = 4;
        idx0 = 14'd300;
        req_mode = 2'b00;
        req = 2'b01;
        wait_evt("t6_wait", 50);
        chk("t6_done", 32'(done), 32'b01);
        chk("t6_bit300", 32'(gvec[300]), 32'd1);
        chk("t6_idx300", 32'(gen_idx), 32'd300);
        req = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed",
                 n_run, n_fail);
        $finish;
    end

endmodule
